load_bus_arbiter: RTL and testbench
===================================

LOAD_BUS_ARBITER -- requirements
Module: load_bus_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DATA_WIDTH, 16, external load bus word width
  K_BURST, 12, words per kernel-load burst
  I_BURST, 4, words per input-load burst
REQ-002 Ports (name  direction  width  meaning), one per line:
  clk  in  1  clock
  arst_n_in  in  1  reset, asynchronous, active-low
  bus_valid  in  1  external word present
  bus_ready  out  1  arbiter accepts word
  bus_data  in  DATA_WIDTH  external word
  k_req  in  1  kernel loader requests a burst
  k_grant  out  1  kernel burst in progress
  k_valid  out  1  kernel word strobe
  k_last  out  1  final kernel word of burst
  i_req  in  1  input loader requests a burst
  i_grant  out  1  input burst in progress
  i_valid  out  1  input word strobe
  i_last  out  1  final input word of burst
  word_data  out  DATA_WIDTH  forwarded word, shared by both requesters
  busy  out  1  burst in progress
REQ-003 The reset is arst_n_in, asynchronous, active-low; the clock is clk; all state updates on the rising clk edge.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, K_BURST and I_BURST.
REQ-005 A register last_srv (K or I) SHALL record the requester served most recently.
REQ-006 A counter cnt SHALL be $clog2(max(K_BURST,I_BURST)) bits wide and count transfers within the current burst.
REQ-007 In IDLE with only k_req high, the next state SHALL be K_BURST.
REQ-008 In IDLE with only i_req high, the next state SHALL be I_BURST.
REQ-009 In IDLE with k_req and i_req both high, the arbiter SHALL grant the requester that is not last_srv (round-robin).
REQ-010 In IDLE with no request, the FSM SHALL stay in IDLE.
REQ-011 On leaving IDLE for a burst, cnt SHALL be cleared to 0 and last_srv SHALL be updated to the granted requester.
REQ-012 k_grant SHALL be 1 exactly when the state is K_BURST; i_grant SHALL be 1 exactly when the state is I_BURST; busy SHALL equal k_grant OR i_grant.
REQ-013 bus_ready SHALL equal busy (combinational from state); it SHALL be 0 in IDLE.
REQ-014 A transfer SHALL occur on any cycle with bus_valid AND bus_ready.
REQ-015 word_data SHALL equal bus_data combinationally.
REQ-016 k_valid SHALL equal bus_valid AND k_grant; i_valid SHALL equal bus_valid AND i_grant. A requester's strobe SHALL never be asserted while it is not granted.
REQ-017 Each transfer SHALL increment cnt by 1.
REQ-018 k_last SHALL equal k_valid AND (cnt==K_BURST-1); i_last SHALL equal i_valid AND (cnt==I_BURST-1).
REQ-019 On the transfer flagged by k_last or i_last, the next state SHALL be IDLE and cnt SHALL return to 0.
REQ-020 Bursts are non-preemptive: deassertion of either req during a burst SHALL be ignored, and the burst SHALL complete all of its words.
REQ-021 bus_valid low during a burst SHALL stall it: cnt and state hold, no strobe is issued, and there is no timeout.
REQ-022 Back-to-back bursts SHALL have exactly one IDLE cycle between them, with bus_ready=0 in that cycle.
REQ-023 Requests are level-sensitive: a req held high through the end of its own burst SHALL be granted again when no other request competes.

Reset
REQ-024 While arst_n_in=0: state SHALL be IDLE, cnt SHALL be 0, and last_srv SHALL be I, so K wins the first tie.
REQ-025 While arst_n_in=0: bus_ready, k_grant, i_grant, k_valid, i_valid, k_last, i_last and busy SHALL all be 0.
REQ-026 Reset asserted mid-burst SHALL abort the burst immediately; no resumption occurs after reset release.

Verification
REQ-027 Reset release, k_req=1, i_req=1, bus_valid=1 constantly -> K_BURST for 12 transfers with k_last on the 12th, then 1 IDLE cycle, then I_BURST for 4 transfers, then K again.
REQ-028 Only i_req=1, bus_valid toggling 1,0,1,0 -> i_valid follows bus_valid, cnt holds during low cycles, i_last on the 4th accepted word after 7 cycles in I_BURST.
REQ-029 k_req pulsed for 1 cycle in IDLE, then 0 -> the full 12-word burst completes; then IDLE with bus_ready=0.
REQ-030 arst_n_in asserted after 5 kernel words -> all outputs 0 asynchronously; after release with k_req=1, a new burst starts with cnt=0 and k_last on the 12th word.
REQ-031 Throughout all scenarios, check invariants: k_valid AND i_valid never both 1; k_grant AND i_grant never both 1; bus_ready=0 in IDLE.

Source files
------------

// File: rtl/load_bus_arbiter_if.sv
// Handshake bundle between the external load bus, the two loaders and the arbiter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface load_bus_arbiter_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  bus_valid;
  logic                  bus_ready;
  logic [DATA_WIDTH-1:0] bus_data;
  logic                  k_req;
  logic                  k_grant;
  logic                  k_valid;
  logic                  k_last;
  logic                  i_req;
  logic                  i_grant;
  logic                  i_valid;
  logic                  i_last;
  logic [DATA_WIDTH-1:0] word_data;
  logic                  busy;

  modport slave (
    input  bus_valid, bus_data, k_req, i_req,
    output bus_ready, k_grant, k_valid, k_last,
    output i_grant, i_valid, i_last, word_data, busy
  );

  modport master (
    output bus_valid, bus_data, k_req, i_req,
    input  bus_ready, k_grant, k_valid, k_last,
    input  i_grant, i_valid, i_last, word_data, busy
  );
endinterface

// File: rtl/load_bus_arbiter.sv
// Round-robin arbiter sharing one external load bus between a kernel loader and an
// input loader; each grant is a fixed-length, non-preemptive burst.
module load_bus_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int K_BURST    = 12,
  parameter int I_BURST    = 4
) (
  input  logic               clk,
  input  logic               arst_n_in,
  load_bus_arbiter_if.slave  lb
);

  localparam int MAX_BURST = (K_BURST > I_BURST) ? K_BURST : I_BURST;
  localparam int CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] K_LAST_CNT = CNT_W'(K_BURST - 1);
  localparam logic [CNT_W-1:0] I_LAST_CNT = CNT_W'(I_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_K_BURST = 2'd1,
    S_I_BURST = 2'd2
  } state_e;

  // Requester identity held in last_srv: 0 = kernel loader, 1 = input loader.
  localparam logic SRV_K = 1'b0;
  localparam logic SRV_I = 1'b1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_srv_q, last_srv_d;

  logic k_grant_s;
  logic i_grant_s;
  logic busy_s;
  logic k_valid_s;
  logic i_valid_s;
  logic xfer_s;

  assign k_grant_s = (state_q == S_K_BURST);
  assign i_grant_s = (state_q == S_I_BURST);
  assign busy_s    = k_grant_s | i_grant_s;
  assign k_valid_s = lb.bus_valid & k_grant_s;
  assign i_valid_s = lb.bus_valid & i_grant_s;
  assign xfer_s    = lb.bus_valid & busy_s;

  assign lb.bus_ready = busy_s;
  assign lb.busy      = busy_s;
  assign lb.k_grant   = k_grant_s;
  assign lb.i_grant   = i_grant_s;
  assign lb.k_valid   = k_valid_s;
  assign lb.i_valid   = i_valid_s;
  assign lb.k_last    = k_valid_s & (cnt_q == K_LAST_CNT);
  assign lb.i_last    = i_valid_s & (cnt_q == I_LAST_CNT);
  assign lb.word_data = lb.bus_data;

  // State, burst counter and round-robin history registers.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= CNT_ZERO;
      last_srv_q <= SRV_I;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_srv_q <= last_srv_d;
    end
  end

  // Next-state logic: arbitration in IDLE, word counting and burst termination otherwise.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_srv_d = last_srv_q;
    case (state_q)
      S_IDLE: begin
        // On a tie the requester that was not served last wins.
        if (lb.k_req && lb.i_req) begin
          cnt_d = CNT_ZERO;
          if (last_srv_q == SRV_I) begin
            state_d    = S_K_BURST;
            last_srv_d = SRV_K;
          end else begin
            state_d    = S_I_BURST;
            last_srv_d = SRV_I;
          end
        end else if (lb.k_req) begin
          state_d    = S_K_BURST;
          cnt_d      = CNT_ZERO;
          last_srv_d = SRV_K;
        end else if (lb.i_req) begin
          state_d    = S_I_BURST;
          cnt_d      = CNT_ZERO;
          last_srv_d = SRV_I;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_K_BURST: begin
        if (xfer_s && (cnt_q == K_LAST_CNT)) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (xfer_s) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_I_BURST: begin
        if (xfer_s && (cnt_q == I_LAST_CNT)) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (xfer_s) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

endmodule

// File: tb/tb_load_bus_arbiter.sv
// Directed-vector bench for load_bus_arbiter: round-robin ties, stalls, non-preemption,
// level-sensitive re-grant and asynchronous mid-burst reset.
module tb_load_bus_arbiter;

  logic clk;
  logic arst_n_in;
  int   n_vec;
  int   n_miscmp;

  load_bus_arbiter_if #(.DATA_WIDTH(16)) lb_if ();

  load_bus_arbiter #(
    .DATA_WIDTH(16),
    .K_BURST   (12),
    .I_BURST   (4)
  ) dut (
    .clk      (clk),
    .arst_n_in(arst_n_in),
    .lb       (lb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_miscmp = n_miscmp + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational outputs, then advance one clock.
  task automatic cyc(input string tag, input logic bv, input logic [15:0] d,
                     input logic kr, input logic ir,
                     input logic ekg, input logic eig, input logic ekl, input logic eil);
    lb_if.bus_valid = bv;
    lb_if.bus_data  = d;
    lb_if.k_req     = kr;
    lb_if.i_req     = ir;
    #1;
    check_val({tag, "_kgrant"}, {31'd0, lb_if.k_grant}, {31'd0, ekg});
    check_val({tag, "_igrant"}, {31'd0, lb_if.i_grant}, {31'd0, eig});
    check_val({tag, "_kvalid"}, {31'd0, lb_if.k_valid}, {31'd0, bv & ekg});
    check_val({tag, "_ivalid"}, {31'd0, lb_if.i_valid}, {31'd0, bv & eig});
    check_val({tag, "_klast"},  {31'd0, lb_if.k_last},  {31'd0, ekl});
    check_val({tag, "_ilast"},  {31'd0, lb_if.i_last},  {31'd0, eil});
    check_val({tag, "_busy"},   {31'd0, lb_if.busy},    {31'd0, ekg | eig});
    check_val({tag, "_ready"},  {31'd0, lb_if.bus_ready}, {31'd0, ekg | eig});
    check_val({tag, "_wdata"},  {16'd0, lb_if.word_data}, {16'd0, d});
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_ready"},  {31'd0, lb_if.bus_ready}, 32'd0);
    check_val({tag, "_kgrant"}, {31'd0, lb_if.k_grant},   32'd0);
    check_val({tag, "_igrant"}, {31'd0, lb_if.i_grant},   32'd0);
    check_val({tag, "_kvalid"}, {31'd0, lb_if.k_valid},   32'd0);
    check_val({tag, "_ivalid"}, {31'd0, lb_if.i_valid},   32'd0);
    check_val({tag, "_klast"},  {31'd0, lb_if.k_last},    32'd0);
    check_val({tag, "_ilast"},  {31'd0, lb_if.i_last},    32'd0);
    check_val({tag, "_busy"},   {31'd0, lb_if.busy},      32'd0);
  endtask

  // Invariants sampled on the falling edge, away from input changes.
  always @(negedge clk) begin
    if (arst_n_in) begin
      check_val("inv_both_valid", {31'd0, lb_if.k_valid & lb_if.i_valid}, 32'd0);
      check_val("inv_both_grant", {31'd0, lb_if.k_grant & lb_if.i_grant}, 32'd0);
      if (!lb_if.k_grant && !lb_if.i_grant) begin
        check_val("inv_idle_ready", {31'd0, lb_if.bus_ready}, 32'd0);
      end
    end
  end

  initial begin
    n_vec    = 0;
    n_miscmp = 0;

    // Reset with every input asserted: all outputs must stay low.
    arst_n_in       = 1'b0;
    lb_if.bus_valid = 1'b1;
    lb_if.bus_data  = 16'h5A5A;
    lb_if.k_req     = 1'b1;
    lb_if.i_req     = 1'b1;
    #3;
    check_reset_outs("rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    arst_n_in = 1'b1;

    // Both requesting constantly: K first (last_srv resets to I), gap, I, gap, K again.
    cyc("s1_idle", 1'b1, 16'h1F00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 12; w++)
      cyc("s1_k", 1'b1, 16'h1000 + 16'(w), 1'b1, 1'b1, 1'b1, 1'b0, (w == 11), 1'b0);
    cyc("s1_gap1", 1'b1, 16'h1F01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 4; w++)
      cyc("s1_i", 1'b1, 16'h2000 + 16'(w), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, (w == 3));
    cyc("s1_gap2", 1'b1, 16'h1F02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Requests dropped mid-burst: the kernel burst still runs all 12 words.
    for (int w = 0; w < 12; w++)
      cyc("s1_k2", 1'b1, 16'h3000 + 16'(w), 1'b0, 1'b0, 1'b1, 1'b0, (w == 11), 1'b0);
    cyc("s1_idle_a", 1'b1, 16'h1F03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("s1_idle_b", 1'b1, 16'h1F04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Input burst with bus_valid toggling: 7 cycles, i_last on the 4th accepted word.
    cyc("s2_idle", 1'b0, 16'h4F00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++)
      cyc("s2_i", (c % 2 == 0), 16'h4000 + 16'(c), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, (c == 6));
    // i_req still high and uncontested: re-granted after exactly one idle cycle.
    cyc("s2_gap", 1'b1, 16'h4F01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 4; w++)
      cyc("s2_i2", 1'b1, 16'h4100 + 16'(w), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (w == 3));
    // Tie after serving I goes to K.
    cyc("s2_tie", 1'b1, 16'h4F02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 12; w++)
      cyc("s2_k", 1'b1, 16'h4200 + 16'(w), 1'b0, 1'b0, 1'b1, 1'b0, (w == 11), 1'b0);
    cyc("s2_end", 1'b1, 16'h4F03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // One-cycle k_req pulse, two stall cycles, then the full burst.
    cyc("s3_pulse", 1'b0, 16'h5F00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("s3_stall0", 1'b0, 16'h5F01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("s3_stall1", 1'b0, 16'h5F02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 12; w++)
      cyc("s3_k", 1'b1, 16'h5000 + 16'(w), 1'b0, 1'b0, 1'b1, 1'b0, (w == 11), 1'b0);
    cyc("s3_idle_a", 1'b1, 16'h5F03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("s3_idle_b", 1'b1, 16'h5F04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset after 5 kernel words aborts the burst; a fresh one restarts from word 0.
    cyc("s4_req", 1'b1, 16'h6F00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 5; w++)
      cyc("s4_k", 1'b1, 16'h6000 + 16'(w), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    arst_n_in = 1'b0;
    #1;
    check_reset_outs("s4_arst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    arst_n_in = 1'b1;
    cyc("s4_idle", 1'b1, 16'h6F01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 12; w++)
      cyc("s4_k2", 1'b1, 16'h6100 + 16'(w), (w == 0), 1'b0, 1'b1, 1'b0, (w == 11), 1'b0);
    cyc("s4_end", 1'b1, 16'h6F02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
